// File: rtl/alu_muldiv_seq.sv
// Sequential 32-bit unsigned multiplier / restoring divider that performs all
// of its add/subtract work through an external shared ALU, one iteration per cycle.
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic [31:0] Rm,
  output logic        dz,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [1:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_z
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] q_q;
  logic [31:0] rm_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;

  logic [31:0] mulAcc_d;
  logic [31:0] divT;
  logic        divC;
  logic        divBorrow;
  logic        quoBit;
  logic [31:0] divRem_d;
  logic [31:0] divDvd_d;
  logic        unusedZero;

  assign unusedZero = alu_z;

  // In MUL, acc_q is the running product, a_q the multiplier, b_q the shifted
  // multiplicand. In DIV, acc_q is the remainder, a_q the dividend/quotient, b_q the divisor.
  assign mulAcc_d  = a_q[0] ? alu_r : acc_q;
  assign divT      = {acc_q[30:0], a_q[31]};
  assign divC      = acc_q[31];
  assign divBorrow = (~divT[31] & b_q[31]) | (~(divT[31] ^ b_q[31]) & alu_r[31]);
  assign quoBit    = divC | ~divBorrow;
  assign divRem_d  = quoBit ? alu_r : divT;
  assign divDvd_d  = {a_q[30:0], quoBit};

  always_comb begin
    alu_x    = 32'd0;
    alu_y    = 32'd0;
    alu_aluc = ALU_ADD;
    case (state_q)
      MUL: begin
        alu_x    = acc_q;
        alu_y    = b_q;
        alu_aluc = ALU_ADD;
      end
      DIV: begin
        alu_x    = divT;
        alu_y    = b_q;
        alu_aluc = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      q_q     <= 32'd0;
      rm_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            cnt_q <= 6'd0;
            acc_q <= 32'd0;
            dz_q  <= 1'b0;
            if (!op) begin
              a_q     <= B;
              b_q     <= A;
              busy_q  <= 1'b1;
              state_q <= MUL;
            end else if (B != 32'd0) begin
              a_q     <= A;
              b_q     <= B;
              busy_q  <= 1'b1;
              state_q <= DIV;
            end else begin
              // Divide by zero completes immediately without touching the ALU.
              a_q     <= A;
              b_q     <= B;
              q_q     <= 32'hFFFF_FFFF;
              rm_q    <= A;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        MUL: begin
          acc_q <= mulAcc_d;
          b_q   <= b_q << 1;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            q_q     <= mulAcc_d;
            rm_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DIV: begin
          acc_q <= divRem_d;
          a_q   <= divDvd_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            q_q     <= divDvd_d;
            rm_q    <= divRem_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Q    = q_q;
  assign Rm   = rm_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq; models the shared ALU and checks results,
// latency, busy/done behaviour, ignored starts and mid-operation reset.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] Rm;
  logic        dz;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [1:0]  alu_aluc;
  logic [31:0] alu_r;
  logic        alu_z;

  int checks = 0;
  int errors = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .Rm(Rm), .dz(dz),
    .alu_x(alu_x), .alu_y(alu_y), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  // Shared ALU behavioural model
  always_comb begin
    case (alu_aluc)
      2'b00:   alu_r = alu_x + alu_y;
      2'b01:   alu_r = alu_x - alu_y;
      2'b10:   alu_r = alu_x & alu_y;
      default: alu_r = alu_x | alu_y;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  // Issues one request and observes it; lat is the edge count after the accept edge at which done was seen (-1 = never).
  task automatic doOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int busyCnt, output logic [31:0] q,
                      output logic [31:0] rm, output logic dzv, output logic doneAfter,
                      output logic [1:0] aluc0, output logic [31:0] aluy0);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    aluc0 = alu_aluc; aluy0 = alu_y;
    lat = -1; busyCnt = 0; q = '0; rm = '0; dzv = 1'b0; doneAfter = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (busy) busyCnt++;
      if (done) begin
        lat = k; q = Q; rm = Rm; dzv = dz;
        @(posedge clk); #1;
        doneAfter = done;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dz got %0b want 0", dz); end
    checks++; if (Q !== 32'd0) begin errors++; $display("[TB] FAIL reset_Q got %h want 0", Q); end
    checks++; if (Rm !== 32'd0) begin errors++; $display("[TB] FAIL reset_Rm got %h want 0", Rm); end
    checks++; if ({alu_x, alu_y, alu_aluc} !== 66'd0) begin errors++; $display("[TB] FAIL reset_alu got x=%h y=%h c=%b want 0", alu_x, alu_y, alu_aluc); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc; logic [31:0] q, rm, ay; logic dzv, da; logic [1:0] ac;
    doOp(1'b0, 32'd7, 32'd6, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (lat !== 32) begin errors++; $display("[TB] FAIL mul_latency got %0d want 32", lat); end
    checks++; if (bc !== 32) begin errors++; $display("[TB] FAIL mul_busy_cycles got %0d want 32", bc); end
    checks++; if (q !== 32'd42) begin errors++; $display("[TB] FAIL mul_7x6_Q got %0d want 42", q); end
    checks++; if (rm !== 32'd0) begin errors++; $display("[TB] FAIL mul_7x6_Rm got %0d want 0", rm); end
    checks++; if (dzv !== 1'b0) begin errors++; $display("[TB] FAIL mul_dz got %0b want 0", dzv); end
    checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_width got %0b want 0", da); end
    checks++; if (ac !== 2'b00 || ay !== 32'd7) begin errors++; $display("[TB] FAIL mul_alu_drive got c=%b y=%h want c=00 y=7", ac, ay); end
    doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (q !== 32'h1 || rm !== 32'h0) begin errors++; $display("[TB] FAIL mul_wrap got Q=%h Rm=%h want Q=1 Rm=0", q, rm); end
  endtask

  task automatic test_div();
    int lat, bc; logic [31:0] q, rm, ay; logic dzv, da; logic [1:0] ac;
    doOp(1'b1, 32'd100, 32'd7, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (q !== 32'd14 || rm !== 32'd2) begin errors++; $display("[TB] FAIL div_100_7 got Q=%0d Rm=%0d want Q=14 Rm=2", q, rm); end
    checks++; if (lat !== 32 || bc !== 32) begin errors++; $display("[TB] FAIL div_timing got lat=%0d busy=%0d want 32/32", lat, bc); end
    checks++; if (ac !== 2'b01 || ay !== 32'd7) begin errors++; $display("[TB] FAIL div_alu_drive got c=%b y=%h want c=01 y=7", ac, ay); end
    doOp(1'b1, 32'hFFFF_FFFF, 32'd1, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (q !== 32'hFFFF_FFFF || rm !== 32'd0) begin errors++; $display("[TB] FAIL div_max_by_1 got Q=%h Rm=%h want Q=ffffffff Rm=0", q, rm); end
    doOp(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (q !== 32'd1 || rm !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL div_max_by_msb got Q=%h Rm=%h want Q=1 Rm=7fffffff", q, rm); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [31:0] q, rm, ay; logic dzv, da; logic [1:0] ac;
    doOp(1'b1, 32'd5, 32'd0, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (lat !== 0 || bc !== 0) begin errors++; $display("[TB] FAIL dz_timing got lat=%0d busy=%0d want 0/0", lat, bc); end
    checks++; if (dzv !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag got %0b want 1", dzv); end
    checks++; if (q !== 32'hFFFF_FFFF || rm !== 32'd5) begin errors++; $display("[TB] FAIL dz_result got Q=%h Rm=%h want Q=ffffffff Rm=5", q, rm); end
    checks++; if (da !== 1'b0) begin errors++; $display("[TB] FAIL dz_done_width got %0b want 0", da); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dz !== 1'b1 || Q !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dz_hold got dz=%0b Q=%h want 1/ffffffff", dz, Q); end
    doOp(1'b0, 32'd2, 32'd9, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (dzv !== 1'b0 || q !== 32'd18) begin errors++; $display("[TB] FAIL dz_clear got dz=%0b Q=%0d want 0/18", dzv, q); end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic [31:0] q;
    @(negedge clk);
    op = 1'b0; A = 32'd7; B = 32'd6; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1; q = '0;
    for (int k = 6; k < 40; k++) begin
      if (done) begin lat = k; q = Q; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 32 || q !== 32'd42) begin errors++; $display("[TB] FAIL restart_mid_mul got lat=%0d Q=%0d want 32/42", lat, q); end
    // Start held across the DONE->IDLE edge must not launch a new operation.
    start = 1'b1; op = 1'b0; A = 32'd3; B = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || Q !== 32'd42) begin errors++; $display("[TB] FAIL start_in_done got busy=%0b done=%0b Q=%0d want 0/0/42", busy, done, Q); end
  endtask

  task automatic test_reset_mid_div();
    int lat, bc; logic [31:0] q, rm, ay; logic dzv, da; logic [1:0] ac;
    logic sawDone;
    @(negedge clk);
    op = 1'b1; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1; #1;
    checks++; if ({busy, done, dz} !== 3'b000 || Q !== 32'd0 || Rm !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_div got busy=%0b done=%0b dz=%0b Q=%h Rm=%h want all 0", busy, done, dz, Q, Rm); end
    checks++; if ({alu_x, alu_y, alu_aluc} !== 66'd0) begin errors++; $display("[TB] FAIL rst_mid_div_alu got x=%h y=%h c=%b want 0", alu_x, alu_y, alu_aluc); end
    @(posedge clk); #1; rst = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_done got activity=%0b want 0", sawDone); end
    doOp(1'b0, 32'd3, 32'd4, lat, bc, q, rm, dzv, da, ac, ay);
    checks++; if (q !== 32'd12 || lat !== 32) begin errors++; $display("[TB] FAIL after_rst_mul got Q=%0d lat=%0d want 12/32", q, lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
